// File: rtl/uart_row_tx.sv
// uart_row_tx: reads a 16-character row from a row source and transmits it as
// 8N1 UART followed by CR LF.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   send       start request, sampled only while idle
//   charIndex  character index presented to the row source
//   charByte   character byte returned by the row source
//   uart_tx    serial line, idle high
//   busy       high while a line is in progress
//   done       one-cycle pulse once the LF stop bit has completed
module uart_row_tx #(
  parameter int unsigned DELAY_FRAMES = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       send,
  output logic [3:0] charIndex,
  input  logic [7:0] charByte,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned BAUD_W = (DELAY_FRAMES > 2) ? $clog2(DELAY_FRAMES) : 1;
  localparam int unsigned POS_W  = 5;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DELAY_FRAMES - 1);
  localparam logic [POS_W-1:0]  POS_LAST_CHAR = POS_W'(15);
  localparam logic [POS_W-1:0]  POS_CR = POS_W'(16);
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    NEXT  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              fetch_q, fetch_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        index_d;
  logic              tx_d, busy_d, done_d;
  logic              baud_end_c;

  assign baud_end_c = (baud_q == BAUD_LAST);

  // State and datapath registers; line outputs lag the state by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      fetch_q   <= 1'b0;
      pos_q     <= '0;
      shift_q   <= '0;
      charIndex <= '0;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      fetch_q   <= fetch_d;
      pos_q     <= pos_d;
      shift_q   <= shift_d;
      charIndex <= index_d;
      uart_tx   <= tx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Next-state, datapath and output decode
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    fetch_d = fetch_q;
    pos_d   = pos_q;
    shift_d = shift_q;
    index_d = charIndex;
    tx_d    = 1'b1;
    busy_d  = (state_q != IDLE);
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (send) begin
          pos_d   = '0;
          index_d = '0;
          fetch_d = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        // Two cycles give a registered row source time to answer
        if (fetch_q) begin
          shift_d = charByte;
          baud_d  = '0;
          state_d = START;
        end else begin
          fetch_d = 1'b1;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (baud_end_c) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_end_c) begin
          baud_d  = '0;
          state_d = NEXT;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      NEXT: begin
        // pos 0..15 are row characters, 16 is CR, 17 is LF
        if (pos_q < POS_LAST_CHAR) begin
          pos_d   = pos_q + POS_W'(1);
          index_d = 4'(pos_q + POS_W'(1));
          fetch_d = 1'b0;
          state_d = FETCH;
        end else if (pos_q == POS_LAST_CHAR) begin
          pos_d   = POS_CR;
          shift_d = CHAR_CR;
          state_d = START;
        end else if (pos_q == POS_CR) begin
          pos_d   = pos_q + POS_W'(1);
          shift_d = CHAR_LF;
          state_d = START;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_row_tx.sv
// Directed bench for uart_row_tx at DELAY_FRAMES=4 with a registered row model
// and a line decoder that collects received bytes.
module tb_uart_row_tx;

  localparam int unsigned DF = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       send;
  logic [3:0] charIndex;
  logic [7:0] charByte;
  logic       uart_tx;
  logic       busy;
  logic       done;

  logic [7:0] row_base;
  logic [7:0] rx_q[$];
  int         done_cnt;
  int         tests;
  int         failed;

  uart_row_tx #(.DELAY_FRAMES(DF)) dut (
    .clk(clk), .reset(reset), .send(send), .charIndex(charIndex),
    .charByte(charByte), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Row source with a one-cycle registered output
  always @(posedge clk) charByte <= row_base + 8'(charIndex);

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Decoder: sample each bit about 2.5 cycles into its period
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (uart_tx === 1'b0) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DF) @(negedge clk);
        b[i] = uart_tx;
      end
      repeat (DF) @(negedge clk);
      rx_q.push_back(b);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse send for one edge; returns after that edge (+1)
  task automatic pulse_send();
    @(negedge clk);
    send = 1'b1;
    @(posedge clk);
    #1 send = 1'b0;
  endtask

  // Count edges until done is seen, bounded
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk);
      #1 n++;
      if (done === 1'b1) break;
    end
  endtask

  task automatic check_line(input string tag, input int base);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(base + 18));
    if (rx_q.size() >= base + 18) begin
      for (int i = 0; i < 16; i++)
        check($sformatf("%s_char%0d", tag, i), 32'(rx_q[base + i]), 32'(8'h41 + 8'(i)));
      check({tag, "_cr"}, 32'(rx_q[base + 16]), 32'h0D);
      check({tag, "_lf"}, 32'(rx_q[base + 17]), 32'h0A);
    end
  endtask

  initial begin
    int n;
    int bad;
    logic [9:0] frame;
    tests = 0; failed = 0; done_cnt = 0;
    reset = 1'b1; send = 1'b0; row_base = 8'h41;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_idx", 32'(charIndex), 32'd0);
    @(negedge clk) reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Single line, timing from first FETCH cycle to done
    rx_q.delete(); done_cnt = 0;
    pulse_send();
    wait_done(2000, n);
    check("line_done_latency", 32'(n), 32'd770);
    check("line_idx_hold", 32'(charIndex), 32'd15);
    repeat (20) @(posedge clk);
    check_line("line1", 0);
    check("line1_done_cnt", 32'(done_cnt), 32'd1);
    check("line1_busy_end", 32'(busy), 32'd0);

    // Bit timing for 0x55
    row_base = 8'h55;
    rx_q.delete(); done_cnt = 0;
    pulse_send();                       // now just after edge T
    @(posedge clk); #1;                 // after T+1
    check("bt_busy", 32'(busy), 32'd1);
    check("bt_idx", 32'(charIndex), 32'd0);
    @(posedge clk); #1;                 // after T+2
    check("bt_pre_start", 32'(uart_tx), 32'd1);
    frame = {1'b1, 8'h55, 1'b0};
    bad = 0;
    for (int j = 0; j < 10 * DF; j++) begin
      @(posedge clk); #1;
      if (uart_tx !== frame[j / DF]) bad++;
    end
    check("bt_levels", 32'(bad), 32'd0);
    wait_done(2000, n);
    check("bt_done_seen", 32'(done), 32'd1);
    repeat (20) @(posedge clk);
    check("bt_first_byte", 32'(rx_q[0]), 32'h55);

    // send pulsed mid-line is ignored
    row_base = 8'h41;
    rx_q.delete(); done_cnt = 0;
    pulse_send();
    n = 0;
    while (charIndex !== 4'd5 && n < 2000) begin @(posedge clk); #1 n++; end
    check("mid_reach_c5", 32'(charIndex), 32'd5);
    repeat (20) @(posedge clk);
    pulse_send();
    wait_done(2000, n);
    repeat (300) @(posedge clk);
    check_line("mid", 0);
    check("mid_done_cnt", 32'(done_cnt), 32'd1);
    check("mid_busy_end", 32'(busy), 32'd0);

    // send held for two lines
    rx_q.delete(); done_cnt = 0;
    @(negedge clk) send = 1'b1;
    wait_done(2000, n);
    check("held_done1", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("held_gap_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("held_gap_busy", 32'(busy), 32'd1);
    repeat (100) @(posedge clk);
    send = 1'b0;
    wait_done(2000, n);
    check("held_done2", 32'(done), 32'd1);
    repeat (300) @(posedge clk);
    check_line("held", 18);
    check("held_l1_lf", 32'(rx_q[17]), 32'h0A);
    check("held_done_cnt", 32'(done_cnt), 32'd2);

    // Reset during DATA of char 7, then a clean line
    pulse_send();
    n = 0;
    while (charIndex !== 4'd7 && n < 2000) begin @(posedge clk); #1 n++; end
    check("rst_reach_c7", 32'(charIndex), 32'd7);
    repeat (10) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx", 32'(uart_tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk) reset = 1'b0;
    repeat (60) @(posedge clk);
    rx_q.delete(); done_cnt = 0;
    pulse_send();
    @(posedge clk); #1;
    check("restart_idx", 32'(charIndex), 32'd0);
    wait_done(2000, n);
    check("restart_latency", 32'(n + 1), 32'd770);
    repeat (20) @(posedge clk);
    check_line("restart", 0);
    check("restart_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_row_tx.md
# uart_row_tx

Transmit-side counterpart to the UART text-row buffer: on a `send` pulse, reads one 16-character display row through the row's character-index/byte interface. Serialises each character as 8N1 UART on `uart_tx`, then sends CR LF. Sits between any row source (text, binary, hex/dec rows) and the board's UART TX pin, so the OLED contents can be echoed to a host terminal.

## Interface
- `DELAY_FRAMES`, default 234: clock cycles per UART bit (27 MHz / 115200). Must be ≥ 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `send`  input  1  start request; sampled only in IDLE; level or pulse accepted.
- `charIndex`  output  4  character index presented to the row source (0..15).
- `charByte`  input  8  character byte returned by the row source. Valid ≤ 2 cycles after `charIndex` changes.
- `uart_tx`  output  1  serial line, idle high.
- `busy`  output  1  high from the cycle after `send` is accepted until return to IDLE.
- `done`  output  1  one-cycle pulse on completion of the LF stop bit.

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `done`=0, `charIndex`=0, state IDLE, bit/baud/char counters 0.
- States: IDLE → FETCH → START → DATA → STOP → NEXT → (FETCH | START | IDLE).
- IDLE: `uart_tx`=1, `busy`=0. If `send`=1, then: charPos←0, `charIndex`←0, fetch counter←0, go to FETCH.
- FETCH: hold `charIndex`=charPos for exactly 2 cycles. At the end of the 2nd cycle, latch `charByte` into the shift register and go to START.
- START: `uart_tx`=0 for DELAY_FRAMES cycles.
- DATA: 8 bits, LSB first, each bit DELAY_FRAMES cycles. Bit counter 0..7, then go to STOP.
- STOP: `uart_tx`=1 for DELAY_FRAMES cycles, then go to NEXT.
- NEXT (1 cycle, `uart_tx`=1):
  - charPos 0..14: charPos+1, go to FETCH.
  - charPos 15: load 0x0D, go to START (no fetch).
  - after CR (charPos 16): load 0x0A, go to START.
  - after LF (charPos 17): pulse `done`, go to IDLE.
- charPos is 5 bits (0..17). `charIndex` = charPos[3:0], updated only on entry to FETCH; it holds 15 during CR/LF.
- `send` while busy: ignored, never queued. `send` held high: a new line starts immediately after IDLE is re-entered, one idle cycle between lines.
- Bytes are sent verbatim; no filtering of control or non-printable codes.
- Reset mid-operation: the next cycle forces `uart_tx`=1 and IDLE, aborting the frame. A truncated frame on the line is acceptable.

## Timing
- `send` high in IDLE at edge T → `busy`=1 and `charIndex`=0 after T+1. The start bit begins at T+3.
- Per character: 2 fetch cycles + 10·DELAY_FRAMES bit cycles + 1 NEXT cycle.
- CR/LF: 10·DELAY_FRAMES + 1 cycles each (no fetch).
- Full line: 18·(10·DELAY_FRAMES+1) + 32 cycles from first FETCH to `done`.
- `done` is high for exactly one cycle: the NEXT cycle after the LF stop bit. `busy` falls the following cycle.
- Bit boundaries are exact: the baud counter runs 0..DELAY_FRAMES−1 and rolls over to 0 on each bit transition, with no drift across the line.
- Row sources with a 1-cycle registered output are covered by the 2-cycle fetch. Combinational sources also work.

## Test plan
- Reset/idle, DELAY_FRAMES=4: assert `reset` 3 cycles → `uart_tx`=1, `busy`=0, `done`=0, `charIndex`=0; stays idle with `send`=0 for 100 cycles.
- Single line, DELAY_FRAMES=4, row model returns "A"+index with a 1-cycle registered output: one `send` pulse. A bench UART decoder must receive 0x41..0x50 then 0x0D 0x0A. `done` pulses once, 18·41+32=770 cycles after the first FETCH cycle.
- Bit timing: character 0x55 at DELAY_FRAMES=4 → line is 0 then 1,0,1,0,1,0,1,0, then 1. Each level lasts exactly 4 cycles, start bit beginning 3 cycles after `send`.
- `send` pulsed mid-line (during char 5) → ignored; exactly 18 bytes sent and one `done`.
- `send` held high for 2 lines → two full 18-byte sequences, one idle cycle between the LF stop bit and the next FETCH, two `done` pulses.
- Reset during DATA of char 7 → `uart_tx`=1 and `busy`=0 the next cycle. A later `send` restarts from `charIndex`=0 and sends a clean full line.
